// File: rtl/reg_file_ctx_if.sv
// Bus bundle for reg_file_ctx: write-back, read ports and context-stack control/status.
// The master drives write-back, read codes and push/pop; the slave returns reads and stack status.
interface reg_file_ctx_if #(
   parameter int NUM_RD    = 3,
   parameter int CTX_DEPTH = 16
);
   localparam int LVL_W = $clog2(CTX_DEPTH + 1);

   logic                  wb_flag;
   logic [7:0]            wb_code;
   logic [31:0]           wb_data;
   logic [8*NUM_RD-1:0]   rd_code;
   logic [32*NUM_RD-1:0]  rd_data;
   logic                  ctx_push;
   logic                  ctx_pop;
   logic [LVL_W-1:0]      ctx_level;
   logic                  ctx_full;
   logic                  ctx_empty;
   logic                  ctx_ovf;
   logic                  ctx_unf;

   modport master (
      output wb_flag, wb_code, wb_data, rd_code, ctx_push, ctx_pop,
      input  rd_data, ctx_level, ctx_full, ctx_empty, ctx_ovf, ctx_unf
   );

   modport slave (
      input  wb_flag, wb_code, wb_data, rd_code, ctx_push, ctx_pop,
      output rd_data, ctx_level, ctx_full, ctx_empty, ctx_ovf, ctx_unf
   );
endinterface

// File: rtl/reg_file_ctx.sv
// Lane-addressed GPR file with a hardware context stack for CALL/RET, updating on the falling clock edge.
// Optional macro RF_BYPASS_EN adds zero-cycle write-back forwarding to the read ports.
module reg_file_ctx #(
   parameter int NUM_REGS  = 4,
   parameter int NUM_RD    = 3,
   parameter int CTX_DEPTH = 16
) (
   input logic           clock,
   input logic           reset,
   reg_file_ctx_if.slave bus
);
   localparam int LVL_W = $clog2(CTX_DEPTH + 1);
   localparam int IDX_W = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;

   // Code layout: [7]=1, [6:5]=register index, [4:3]=00, [2:0]=lane; lane 100 is reserved.
   function automatic logic codeValid(input logic [7:0] code);
      return code[7] && (code[4:3] == 2'b00) && (code[2:0] != 3'b100)
             && (int'(code[6:5]) < NUM_REGS);
   endfunction

   function automatic logic [31:0] laneMask(input logic [2:0] lane);
      logic [31:0] mask;
      mask = 32'h0000_0000;
      case (lane)
         3'b000:                 mask = 32'hFFFF_FFFF;
         3'b001, 3'b101:         mask = 32'h0000_FFFF;
         3'b010, 3'b011,
         3'b110, 3'b111:         mask = 32'h0000_00FF;
         default:                mask = 32'h0000_0000;
      endcase
      return mask;
   endfunction

   function automatic logic [4:0] laneShift(input logic [2:0] lane);
      logic [4:0] sh;
      sh = 5'd0;
      case (lane)
         3'b011:                 sh = 5'd8;
         3'b101, 3'b110:         sh = 5'd16;
         3'b111:                 sh = 5'd24;
         default:                sh = 5'd0;
      endcase
      return sh;
   endfunction

   function automatic logic [31:0] laneRead(input logic [31:0] value, input logic [2:0] lane);
      return (value >> laneShift(lane)) & laneMask(lane);
   endfunction

   function automatic logic [31:0] laneMerge(input logic [31:0] value, input logic [2:0] lane,
                                             input logic [31:0] data);
      logic [31:0] fieldMask;
      fieldMask = laneMask(lane) << laneShift(lane);
      return (value & ~fieldMask) | ((data & laneMask(lane)) << laneShift(lane));
   endfunction

   logic [31:0]            r_gpr [NUM_REGS];
   logic [32*NUM_REGS-1:0] r_stack [CTX_DEPTH];
   logic [LVL_W-1:0]       r_level;
   logic                   r_ovf;
   logic                   r_unf;

   logic                   w_full;
   logic                   w_empty;
   logic                   w_wbValid;
   logic [1:0]             w_wbIdx;
   logic                   w_doPush;
   logic                   w_doPop;
   logic                   w_pushBlocked;
   logic                   w_popBlocked;
   logic [IDX_W-1:0]       w_pushIdx;
   logic [IDX_W-1:0]       w_popIdx;
   logic [32*NUM_REGS-1:0] w_gprFlat;
   logic [31:0]            w_gprNext [NUM_REGS];
   logic [31:0]            w_rdSrc [NUM_RD];
   logic [32*NUM_RD-1:0]   w_rdPacked;

   assign w_full        = (r_level == LVL_W'(CTX_DEPTH));
   assign w_empty       = (r_level == '0);
   assign w_wbValid     = bus.wb_flag && codeValid(bus.wb_code);
   assign w_wbIdx       = bus.wb_code[6:5];
   assign w_doPush      = bus.ctx_push && !bus.ctx_pop && !w_full;
   assign w_doPop       = bus.ctx_pop && !bus.ctx_push && !w_empty;
   assign w_pushBlocked = bus.ctx_push && !bus.ctx_pop && w_full;
   assign w_popBlocked  = bus.ctx_pop && !bus.ctx_push && w_empty;
   assign w_pushIdx     = IDX_W'(r_level);
   assign w_popIdx      = IDX_W'(r_level - LVL_W'(1));

   always_comb begin
      w_gprFlat = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_gprFlat[32*r +: 32] = r_gpr[r];
      end
   end

   // Restore from the stack first, then let the write-back lane override it.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         w_gprNext[r] = r_gpr[r];
         if (w_doPop) begin
            w_gprNext[r] = r_stack[w_popIdx][32*r +: 32];
         end
         if (w_wbValid && (w_wbIdx == 2'(r))) begin
            w_gprNext[r] = laneMerge(w_gprNext[r], bus.wb_code[2:0], bus.wb_data);
         end
      end
   end

   always_comb begin
      w_rdPacked = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         w_rdSrc[p] = 32'h0000_0000;
         for (int r = 0; r < NUM_REGS; r++) begin
            if (bus.rd_code[8*p+5 +: 2] == 2'(r)) begin
               w_rdSrc[p] = r_gpr[r];
            end
         end
`ifdef RF_BYPASS_EN
         if (w_wbValid && !bus.ctx_pop && (w_wbIdx == bus.rd_code[8*p+5 +: 2])) begin
            w_rdSrc[p] = laneMerge(w_rdSrc[p], bus.wb_code[2:0], bus.wb_data);
         end
`endif
         if (codeValid(bus.rd_code[8*p +: 8])) begin
            w_rdPacked[32*p +: 32] = laneRead(w_rdSrc[p], bus.rd_code[8*p +: 3]);
         end
      end
   end

   always_ff @(negedge clock) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_gpr[r] <= 32'h0000_0000;
         end
         r_level <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            r_gpr[r] <= w_gprNext[r];
         end
         if (w_doPush) begin
            r_level <= r_level + LVL_W'(1);
         end else if (w_doPop) begin
            r_level <= r_level - LVL_W'(1);
         end
         if (w_pushBlocked) begin
            r_ovf <= 1'b1;
         end
         if (w_popBlocked) begin
            r_unf <= 1'b1;
         end
      end
   end

   // Stack RAM has no reset; only the level pointer defines which entries are meaningful.
   always_ff @(negedge clock) begin
      if (!reset && w_doPush) begin
         r_stack[w_pushIdx] <= w_gprFlat;
      end
   end

   assign bus.rd_data   = w_rdPacked;
   assign bus.ctx_level = r_level;
   assign bus.ctx_full  = w_full;
   assign bus.ctx_empty = w_empty;
   assign bus.ctx_ovf   = r_ovf;
   assign bus.ctx_unf   = r_unf;
endmodule
